shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl_pkg.sv | 25 ++
 rtl/seq_step_cnt.sv | 57 +++++
 rtl/shift_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// rtl/shift_seq_ctrl_pkg.sv - shared state encoding and shift-register mode codes
//
// Purpose: common types and constants for shift_seq_ctrl and its step counter.
//   state_t    : sequencer FSM states (IDLE, LOAD, SHIFT, FIN)
//   MODE_*     : shift-register S mode codes
//   shift_mode : maps the latched direction bit to its shift mode code
package shift_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_FIN   = 2'b11
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SR   = 2'b01;
  localparam logic [1:0] MODE_SL   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  function automatic logic [1:0] shift_mode(input logic dir);
    return dir ? MODE_SL : MODE_SR;
  endfunction

endpackage

// File: rtl/seq_step_cnt.sv
// rtl/seq_step_cnt.sv - shift step prescaler and remaining-step down-counter
//
// Purpose: times each shift step to STEP_DIV clocks and counts remaining steps.
// Ports:
//   i_clk        : clock
//   i_rst        : asynchronous active-high reset
//   i_load       : load the step counter with i_len
//   i_len        : number of shift steps to run
//   i_run        : high while the sequencer is in SHIFT
//   i_clear      : abort; zero the step counter
//   o_step_done  : strobe in the last cycle of a step
//   o_last_step  : strobe in the last cycle of the final step
module seq_step_cnt #(
  parameter int STEP_DIV = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [3:0] i_len,
  input  logic       i_run,
  input  logic       i_clear,
  output logic       o_step_done,
  output logic       o_last_step
);

  localparam logic [3:0] DIV_M1 = 4'(STEP_DIV - 1);

  logic [3:0] r_presc;
  logic [3:0] r_cnt;

  assign o_step_done = i_run & (r_presc == DIV_M1);
  // Counter still holds 1 during the final step; it reaches 0 as the step ends.
  assign o_last_step = o_step_done & (r_cnt == 4'd1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= 4'd0;
      r_cnt   <= 4'd0;
    end else begin
      // Prescaler idles at 0 so the first SHIFT cycle always starts a step.
      if (!i_run || o_step_done) begin
        r_presc <= 4'd0;
      end else begin
        r_presc <= r_presc + 4'd1;
      end

      if (i_clear) begin
        r_cnt <= 4'd0;
      end else if (i_load) begin
        r_cnt <= i_len;
      end else if (o_step_done && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - load/shift sequencer driving a 4-bit universal shift register
//
// Purpose: on START loads PAT into an external shift register, shifts it LEN
// steps (STEP_DIV clocks each) in direction DIR, then pulses DONE.
// Optional feature macro: SEQ_IDLE_HIZ_EN (OE high-Z in IDLE/FIN; else OE=0).
// Ports:
//   CLK   : clock           CLR  : asynchronous active-high reset
//   START : run request     ABORT: terminate running sequence
//   DIR   : 1 left, 0 right PAT  : load pattern     LEN: shift steps 0..15
//   S     : register mode   D    : parallel data    OE : output enable (active-low)
//   BUSY  : LOAD through last shift step            DONE: completion pulse
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int STEP_DIV = 1
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       START,
  input  logic       ABORT,
  input  logic       DIR,
  input  logic [3:0] PAT,
  input  logic [3:0] LEN,
  output logic [1:0] S,
  output logic [3:0] D,
  output logic       OE,
  output logic       BUSY,
  output logic       DONE
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_dir;
  logic [3:0] r_pat;
  logic [3:0] r_len;
  logic [1:0] r_s;
  logic [3:0] r_d;
  logic       r_busy;
  logic       r_done;
  logic       w_accept;
  logic       w_abort;
  logic       w_step_done;
  logic       w_last_step;
  logic [1:0] w_s_nxt;
  logic [3:0] w_d_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;

  // ABORT wins over START in IDLE; START elsewhere is simply ignored.
  assign w_accept = (r_state == ST_IDLE) & START & ~ABORT;
  assign w_abort  = (r_state != ST_IDLE) & ABORT;

  seq_step_cnt #(
    .STEP_DIV (STEP_DIV)
  ) u_step_cnt (
    .i_clk       (CLK),
    .i_rst       (CLR),
    .i_load      (w_accept),
    .i_len       (LEN),
    .i_run       (r_state == ST_SHIFT),
    .i_clear     (w_abort),
    .o_step_done (w_step_done),
    .o_last_step (w_last_step)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= ST_IDLE;
      r_dir   <= 1'b0;
      r_pat   <= 4'd0;
      r_len   <= 4'd0;
      r_s     <= MODE_HOLD;
      r_d     <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_d     <= w_d_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_dir <= DIR;
        r_pat <= PAT;
        r_len <= LEN;
      end
    end
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = MODE_HOLD;
    w_d_nxt     = 4'd0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = (r_len == 4'd0) ? ST_FIN : ST_SHIFT;
      ST_SHIFT: if (w_last_step) w_state_nxt = ST_FIN;
      ST_FIN:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end

    case (w_state_nxt)
      ST_LOAD: begin
        w_s_nxt    = MODE_LOAD;
        w_d_nxt    = PAT;  // latched in the same edge, so take it from the port
        w_busy_nxt = 1'b1;
      end
      ST_SHIFT: begin
        // Shift code only in the first cycle of each step.
        if ((r_state == ST_LOAD) || w_step_done) begin
          w_s_nxt = shift_mode(r_dir);
        end
        w_d_nxt    = r_pat;
        w_busy_nxt = 1'b1;
      end
      ST_FIN: begin
        w_d_nxt    = r_pat;
        w_done_nxt = 1'b1;
      end
      default: begin
        w_s_nxt = MODE_HOLD;
      end
    endcase
  end

  assign S    = r_s;
  assign D    = r_d;
  assign BUSY = r_busy;
  assign DONE = r_done;

`ifdef SEQ_IDLE_HIZ_EN
  logic r_oe;
  logic w_oe_nxt;

  assign w_oe_nxt = ~((w_state_nxt == ST_LOAD) || (w_state_nxt == ST_SHIFT));

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_oe <= 1'b1;
    end else begin
      r_oe <= w_oe_nxt;
    end
  end

  assign OE = r_oe;
`else
  assign OE = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl (STEP_DIV 1 and 3)
module tb_shift_seq_ctrl;

`ifdef SEQ_IDLE_HIZ_EN
  localparam logic OE_IDLE = 1'b1;
`else
  localparam logic OE_IDLE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic       abort;
  logic       dir;
  logic [3:0] pat;
  logic [3:0] len;
  logic [1:0] s1, s3;
  logic [3:0] d1, d3;
  logic       oe1, oe3, busy1, busy3, done1, done3;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.STEP_DIV(1)) dut1 (
    .CLK(clk), .CLR(clr), .START(start), .ABORT(abort), .DIR(dir), .PAT(pat), .LEN(len),
    .S(s1), .D(d1), .OE(oe1), .BUSY(busy1), .DONE(done1)
  );

  shift_seq_ctrl #(.STEP_DIV(3)) dut3 (
    .CLK(clk), .CLR(clr), .START(start), .ABORT(abort), .DIR(dir), .PAT(pat), .LEN(len),
    .S(s3), .D(d3), .OE(oe3), .BUSY(busy3), .DONE(done3)
  );

  // Expected {S,D,BUSY,DONE,OE} in cycle t after the START edge (t=1 is LOAD);
  // the run ends at an ABORT sampled at the end of cycle a.
  function automatic logic [8:0] exp_out(int t, int sd, int ln, logic dr, logic [3:0] pt, int a);
    int fin = 2 + ln * sd;
    if (t < 1 || t > a || t > fin) return {2'b00, 4'h0, 1'b0, 1'b0, OE_IDLE};
    if (t == 1) return {2'b11, pt, 1'b1, 1'b0, 1'b0};
    if (t == fin) return {2'b00, pt, 1'b0, 1'b1, OE_IDLE};
    if (((t - 2) % sd) == 0) return {(dr ? 2'b10 : 2'b01), pt, 1'b1, 1'b0, 1'b0};
    return {2'b00, pt, 1'b1, 1'b0, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got={S,D,BUSY,DONE,OE}=%b expected=%b", tag, got, expv);
    end
  endtask

  task automatic chk_both(input string tag, input int t, input int ln, input logic dr,
                          input logic [3:0] pt, input int a);
    chk($sformatf("%s sd1 t=%0d", tag, t), {s1, d1, busy1, done1, oe1}, exp_out(t, 1, ln, dr, pt, a));
    chk($sformatf("%s sd3 t=%0d", tag, t), {s3, d3, busy3, done3, oe3}, exp_out(t, 3, ln, dr, pt, a));
  endtask

  // One sequence: a = abort cycle (0: ABORT with START in IDLE), r = cycle of a stray START.
  task automatic run(input string tag, input logic [3:0] pt, input logic dr, input int ln,
                     input int a, input int r);
    int max_t = 2 + ln * 3 + 2;
    start = 1'b1;
    abort = (a == 0);
    pat   = pt;
    dir   = dr;
    len   = 4'(ln);
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    pat   = 4'($urandom);
    dir   = 1'($urandom);
    len   = 4'($urandom);
    for (int t = 1; t <= max_t; t++) begin
      @(negedge clk);
      chk_both(tag, t, ln, dr, pt, a);
      abort = (t == a);
      start = (t == r);
      pat   = 4'($urandom);
      @(posedge clk);
      #1;
      abort = 1'b0;
      start = 1'b0;
    end
  endtask

  initial begin
    clr   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    dir   = 1'b0;
    pat   = 4'h0;
    len   = 4'h0;
    #2;
    chk_both("reset", 0, 0, 1'b0, 4'h0, 1000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk_both("post_reset", 0, 0, 1'b0, 4'h0, 1000);

    run("right_len3", 4'b1000, 1'b0, 3, 1000, 1000);
    run("left_len2", 4'b0001, 1'b1, 2, 1000, 1000);
    run("len0", 4'b0101, 1'b1, 0, 1000, 1000);
    run("restart_shift", 4'b1010, 1'b0, 4, 1000, 3);
    run("start_in_fin", 4'b0110, 1'b1, 2, 1000, 4);
    run("start_abort_idle", 4'b1111, 1'b1, 3, 0, 1000);
    run("abort_step2_sd1", 4'b1001, 1'b0, 5, 3, 1000);
    run("abort_step2_sd3", 4'b1001, 1'b1, 5, 6, 1000);
    run("after_abort", 4'b0011, 1'b1, 1, 1000, 1000);

    // CLR mid-SHIFT forces IDLE asynchronously, without waiting for an edge.
    start = 1'b1; pat = 4'b1100; dir = 1'b1; len = 4'd5; abort = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    clr = 1'b1;
    #1;
    chk_both("clr_immediate", 0, 0, 1'b0, 4'h0, 1000);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk_both("clr_held", 0, 0, 1'b0, 4'h0, 1000);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk_both("clr_released", 0, 0, 1'b0, 4'h0, 1000);
    run("after_clr", 4'b0111, 1'b0, 2, 1000, 1000);

    for (int i = 0; i < 16; i++) begin
      int ln = $urandom_range(0, 15);
      int a  = 1000;
      int r  = 1000;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(1, 2 + ln * 3);
      if ($urandom_range(0, 2) == 0) r = $urandom_range(1, 2 + ln);
      if (r > a) r = 1000;
      run($sformatf("rand%0d", i), 4'($urandom), 1'($urandom), ln, a, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
